// File: rtl/serial2parallel.sv
// Serial-to-parallel receiver for the 3-wire (s_clk, s_clr, s_dat) link.
// Synchronises the serial lines, shifts in one frame and strobes the word out.
module serial2parallel #(
  parameter int DATA_BITS      = 16,
  parameter int CODE_ENDIAN    = 1,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_clk,
  input  logic                 s_clr,
  input  logic                 s_dat,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 busy,
  output logic                 frame_err
);

  localparam int CNT_W = $clog2(DATA_BITS);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, RECV, DONE} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] clk_sync, clr_sync, dat_sync;
  logic                   clk_s, clr_s, dat_s, clk_s_prev, rise;
  logic [DATA_BITS-1:0]   sr;
  logic [CNT_W-1:0]       bit_cnt;
  logic [TO_W-1:0]        to_cnt;
  logic                   abort;

  function automatic logic [DATA_BITS-1:0] shift_in(input logic [DATA_BITS-1:0] cur,
                                                    input logic b);
    if (CODE_ENDIAN != 0) return {cur[DATA_BITS-2:0], b};
    else                  return {b, cur[DATA_BITS-1:1]};
  endfunction

  // Synchroniser stage: equal-depth chains keep data aligned with its clock edge
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync   <= '0;
      clr_sync   <= '0;
      dat_sync   <= '0;
      clk_s_prev <= 1'b0;
    end else begin
      clk_sync   <= {clk_sync[SYNC_STAGES-2:0], s_clk};
      clr_sync   <= {clr_sync[SYNC_STAGES-2:0], s_clr};
      dat_sync   <= {dat_sync[SYNC_STAGES-2:0], s_dat};
      clk_s_prev <= clk_s;
    end
  end

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign clr_s = clr_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];
  assign rise  = clk_s & ~clk_s_prev;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A clear in mid-frame wins over a simultaneous clock rise
  always_comb begin
    state_nxt = state;
    abort     = 1'b0;
    case (state)
      IDLE:  if (clr_s) state_nxt = CLEAR;
      CLEAR: if (!clr_s) state_nxt = RECV;
      RECV: begin
        if (clr_s) begin
          state_nxt = CLEAR;
          abort     = 1'b1;
        end else if (rise) begin
          if (bit_cnt == LAST_BIT) state_nxt = DONE;
        end else if (to_cnt == TO_LAST) begin
          state_nxt = IDLE;
          abort     = 1'b1;
        end
      end
      DONE:    state_nxt = clr_s ? CLEAR : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Frame stage: shift register, counters and output word
  always_ff @(posedge clk) begin
    if (rst) begin
      sr        <= '0;
      bit_cnt   <= '0;
      to_cnt    <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= (state == DONE);
      frame_err <= abort;
      case (state)
        CLEAR: begin
          sr      <= '0;
          bit_cnt <= '0;
          to_cnt  <= '0;
        end
        RECV: begin
          if (!clr_s) begin
            if (rise) begin
              sr      <= shift_in(sr, dat_s);
              bit_cnt <= bit_cnt + CNT_W'(1);
              to_cnt  <= '0;
            end else begin
              to_cnt  <= to_cnt + TO_W'(1);
            end
          end
        end
        DONE:    data <= sr;
        default: ;
      endcase
    end
  end

  assign busy = (state == CLEAR) || (state == RECV);

endmodule

// File: tb/tb_serial2parallel.sv
// Directed bench for serial2parallel: one MSB-first and one LSB-first receiver
// share a bit-level serial driver (s_clk half-period of 10 clk cycles).
module tb_serial2parallel;

  localparam int DB = 16;
  localparam int SS = 2;
  localparam int TO = 64;
  localparam int HP = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_clk = 1'b0;
  logic          s_clr = 1'b0;
  logic          s_dat = 1'b0;
  logic [DB-1:0] data_be, data_le;
  logic          valid_be, valid_le, busy_be, busy_le, ferr_be, ferr_le;

  int n_checks = 0;
  int n_pass   = 0;
  int vcnt_be  = 0;
  int vcnt_le  = 0;
  int fcnt_be  = 0;
  int fcnt_le  = 0;
  int cnt;

  always #5 clk = ~clk;

  serial2parallel #(.DATA_BITS(DB), .CODE_ENDIAN(1), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO)) dut_be (
    .clk(clk), .rst(rst), .s_clk(s_clk), .s_clr(s_clr), .s_dat(s_dat),
    .data(data_be), .valid(valid_be), .busy(busy_be), .frame_err(ferr_be));

  serial2parallel #(.DATA_BITS(DB), .CODE_ENDIAN(0), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO)) dut_le (
    .clk(clk), .rst(rst), .s_clk(s_clk), .s_clr(s_clr), .s_dat(s_dat),
    .data(data_le), .valid(valid_le), .busy(busy_le), .frame_err(ferr_le));

  always @(negedge clk) begin
    if (valid_be) vcnt_be <= vcnt_be + 1;
    if (valid_le) vcnt_le <= vcnt_le + 1;
    if (ferr_be)  fcnt_be <= fcnt_be + 1;
    if (ferr_le)  fcnt_le <= fcnt_le + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
  endtask

  task automatic send_bit(input logic b);
    s_dat = b;
    tick(HP);
    s_clk = 1'b1;
    tick(HP);
    s_clk = 1'b0;
  endtask

  task automatic send_bits(input logic [15:0] w, input int n, input bit lsb_first);
    for (int i = 0; i < n; i++) send_bit(lsb_first ? w[i] : w[15-i]);
  endtask

  task automatic start_frame();
    s_clr = 1'b1;
    tick(HP);
    s_clr = 1'b0;
    tick(HP);
  endtask

  task automatic send_frame(input logic [15:0] w, input bit lsb_first);
    start_frame();
    send_bits(w, 16, lsb_first);
    tick(HP);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    tick(3);
    chk("rst_data_be", data_be, 16'h0000);
    chk("rst_data_le", data_le, 16'h0000);
    chk("rst_valid", valid_be, 1'b0);
    chk("rst_busy", busy_be, 1'b0);
    chk("rst_ferr", ferr_be, 1'b0);
    rst = 1'b0;
    tick(2);

    // MSB-first frames; the LSB-first receiver sees the bit-reversed word
    send_frame(16'hA5C3, 1'b0);
    chk("t1_data_be_a5c3", data_be, 16'hA5C3);
    chk("t1_data_le_rev", data_le, 16'hC3A5);
    chk("t1_busy_between", busy_be, 1'b0);
    send_frame(16'h0001, 1'b0);
    chk("t1_data_be_0001", data_be, 16'h0001);
    chk("t1_data_le_rev2", data_le, 16'h8000);
    chk("t1_valid_cnt", vcnt_be, 2);
    chk("t1_ferr_cnt", fcnt_be, 0);

    // LSB-first frames
    send_frame(16'h8001, 1'b1);
    chk("t2_data_le_8001", data_le, 16'h8001);
    chk("t2_data_be_8001", data_be, 16'h8001);
    send_frame(16'h1234, 1'b1);
    chk("t2_data_le_1234", data_le, 16'h1234);
    chk("t2_data_be_rev", data_be, 16'h2C48);
    chk("t2_valid_cnt_le", vcnt_le, 4);

    // Clear after 5 bits aborts the frame, then a full frame of ones
    start_frame();
    send_bits(16'hFFFF, 5, 1'b0);
    s_clr = 1'b1;
    tick(HP);
    chk("t3_ferr_cnt", fcnt_be, 1);
    chk("t3_busy_in_clear", busy_be, 1'b1);
    chk("t3_data_hold_be", data_be, 16'h2C48);
    chk("t3_data_hold_le", data_le, 16'h1234);
    chk("t3_no_valid", vcnt_be, 4);
    s_clr = 1'b0;
    tick(HP);
    send_bits(16'hFFFF, 16, 1'b0);
    tick(HP);
    chk("t3_data_ffff", data_be, 16'hFFFF);
    chk("t3_data_le_ffff", data_le, 16'hFFFF);
    chk("t3_valid_cnt", vcnt_be, 5);
    chk("t3_ferr_cnt_le", fcnt_le, 1);

    // 7 bits, then s_clk stalls: raw rise -> sync'd rise takes SS+1 cycles, then TO more
    start_frame();
    send_bits(16'h0000, 6, 1'b0);
    s_dat = 1'b0;
    tick(HP);
    s_clk = 1'b1;
    cnt = 0;
    while (cnt < 200) begin
      tick(1);
      cnt++;
      if (cnt == HP) s_clk = 1'b0;
      if (ferr_be) break;
    end
    chk("t4_timeout_latency", cnt, TO + SS + 1);
    chk("t4_ferr_le", ferr_le, 1'b1);
    chk("t4_busy_low", busy_be, 1'b0);
    chk("t4_data_hold", data_be, 16'hFFFF);
    tick(1);
    chk("t4_ferr_one_cycle", ferr_be, 1'b0);
    tick(2);
    chk("t4_ferr_cnt", fcnt_be, 2);

    // Reset during bit 9, then a clean frame
    start_frame();
    send_bits(16'h5A5A, 8, 1'b0);
    s_dat = 1'b0;
    tick(5);
    rst = 1'b1;
    tick(1);
    chk("t5_rst_data_be", data_be, 16'h0000);
    chk("t5_rst_data_le", data_le, 16'h0000);
    chk("t5_rst_valid", valid_be, 1'b0);
    chk("t5_rst_busy", busy_be, 1'b0);
    chk("t5_rst_ferr", ferr_be, 1'b0);
    rst = 1'b0;
    tick(HP);
    chk("t5_no_ferr", fcnt_be, 2);
    send_frame(16'h5A5A, 1'b0);
    chk("t5_data_5a5a", data_be, 16'h5A5A);
    chk("t5_data_le_5a5a", data_le, 16'h5A5A);
    chk("t5_valid_cnt", vcnt_be, 6);

    // Three s_clk rises while s_clr is held, then a frame of 16'h00FF
    s_clr = 1'b1;
    s_dat = 1'b1;
    repeat (3) begin
      tick(HP);
      s_clk = 1'b1;
      tick(HP);
      s_clk = 1'b0;
    end
    tick(HP);
    s_clr = 1'b0;
    tick(HP);
    send_bits(16'h00FF, 16, 1'b0);
    tick(HP);
    chk("t6_data_00ff", data_be, 16'h00FF);
    chk("t6_data_le_rev", data_le, 16'hFF00);
    chk("t6_valid_cnt", vcnt_be, 7);
    chk("t6_ferr_cnt", fcnt_be, 2);
    chk("t6_busy_low", busy_be, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
